// File: rtl/clint_axi_if.sv
// AXI4 channel bundle between the CLINT initiator (master) and the timer slave.
// Only the fields used by single-beat 64-bit accesses are carried.
interface clint_axi_if #(
  parameter int unsigned AXI_ID_WIDTH = 5
);
  // Write address channel
  logic [AXI_ID_WIDTH-1:0] awid;
  logic [63:0]             awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  // Write data channel
  logic [63:0]             wdata;
  logic [7:0]              wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  // Write response channel
  logic [AXI_ID_WIDTH-1:0] bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  // Read address channel
  logic [AXI_ID_WIDTH-1:0] arid;
  logic [63:0]             araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;
  // Read data channel
  logic [AXI_ID_WIDTH-1:0] rid;
  logic [63:0]             rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/clint_axi_initiator.sv
// Single-outstanding AXI4 master for the CLINT timer slave.
// Turns one req/gnt/rvalid register access into one single-beat 64-bit AXI4
// transaction; misaligned addresses complete locally with an error.
module clint_axi_initiator #(
  parameter int unsigned AXI_ID_WIDTH = 5,
  parameter int unsigned AXI_ID       = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [63:0] addr_i,
  input  logic [63:0] wdata_i,
  input  logic [7:0]  be_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [63:0] rdata_o,
  output logic        err_o,
  clint_axi_if.master axi
);

  localparam logic [AXI_ID_WIDTH-1:0] ID = AXI_ID[AXI_ID_WIDTH-1:0];

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WAIT_B,
    RD,
    WAIT_R,
    ERR
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] addr_q, wdata_q;
  logic [7:0]  be_q;
  logic        awvalid_q, wvalid_q, arvalid_q;
  logic        rvalid_q, err_q;
  logic [63:0] rdata_q;
  logic        aw_done, w_done, aligned;

  assign aligned = (addr_i[2:0] == 3'b000);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of process ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state and grant decode.
  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    gnt_o   = 1'b0;
    // A write channel is finished once its valid has dropped or is being accepted now.
    aw_done = !awvalid_q || axi.awready;
    w_done  = !wvalid_q  || axi.wready;
    unique case (state_q)
      IDLE: begin
        gnt_o = req_i;
        if (req_i) begin
          if (!aligned)  state_d = ERR;
          else if (we_i) state_d = WR;
          else           state_d = RD;
        end
      end
      WR:      if (aw_done && w_done) state_d = WAIT_B;
      WAIT_B:  if (axi.bvalid)        state_d = IDLE;
      RD:      if (axi.arready)       state_d = WAIT_R;
      WAIT_R:  if (axi.rvalid)        state_d = IDLE;
      ERR:                            state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  // Command latch, channel valids and completion reporting.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      // Completion is a single-cycle pulse unless re-raised below.
      rvalid_q <= 1'b0;
      if (gnt_o) begin
        addr_q    <= addr_i;
        wdata_q   <= wdata_i;
        be_q      <= be_i;
        awvalid_q <= we_i && aligned;
        wvalid_q  <= we_i && aligned;
        arvalid_q <= !we_i && aligned;
      end
      unique case (state_q)
        WR: begin
          // AW and W retire independently; either may go first.
          if (axi.awready) awvalid_q <= 1'b0;
          if (axi.wready)  wvalid_q  <= 1'b0;
        end
        RD: if (axi.arready) arvalid_q <= 1'b0;
        WAIT_B: if (axi.bvalid) begin
          rvalid_q <= 1'b1;
          err_q    <= axi.bresp[1] | (axi.bid != ID);
        end
        WAIT_R: if (axi.rvalid) begin
          rvalid_q <= 1'b1;
          rdata_q  <= axi.rdata;
          err_q    <= axi.rresp[1] | ~axi.rlast | (axi.rid != ID);
        end
        ERR: begin
          rvalid_q <= 1'b1;
          err_q    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

  assign axi.awid    = ID;
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = 8'd0;
  assign axi.awsize  = 3'd3;
  assign axi.awburst = 2'b01;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = be_q;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = (state_q == WAIT_B);
  assign axi.arid    = ID;
  assign axi.araddr  = addr_q;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = 3'd3;
  assign axi.arburst = 2'b01;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = (state_q == WAIT_R);

endmodule

// File: tb/tb_clint_axi_initiator.sv
// Self-checking bench for clint_axi_initiator: directed scenarios followed by
// randomized accesses against a reactive AXI slave and a rule-based model.
module tb_clint_axi_initiator;

  localparam int unsigned    IDW    = 5;
  localparam int unsigned    AXI_ID = 6;
  localparam logic [IDW-1:0] ID     = 5'd6;

  logic        clk_i, rst_ni, req_i, we_i;
  logic [63:0] addr_i, wdata_i;
  logic [7:0]  be_i;
  logic        gnt_o, rvalid_o, err_o;
  logic [63:0] rdata_o;

  int n_checks = 0;
  int n_bad    = 0;
  int cyc      = 0;

  // Slave behaviour knobs, set by the stimulus before each request.
  int             k_rand_ready = 0;
  int             k_w_hold     = 0;
  int             k_b_delay    = 0;
  int             k_r_delay    = 0;
  logic [1:0]     k_bresp      = 2'b00;
  logic [1:0]     k_rresp      = 2'b00;
  logic [IDW-1:0] k_bid        = ID;
  logic [IDW-1:0] k_rid        = ID;
  logic           k_rlast      = 1'b1;
  logic [63:0]    k_rdata      = '0;

  // What the slave saw on the bus.
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
  logic [63:0] obs_awaddr, obs_araddr, obs_wdata;
  logic [7:0]  obs_wstrb;
  logic        obs_wlast, obs_aw_fixed, obs_ar_fixed;

  // Reference model state: last completed read data.
  logic [63:0] last_rdata = '0;

  clint_axi_if #(.AXI_ID_WIDTH(IDW)) axi ();

  clint_axi_initiator #(.AXI_ID_WIDTH(IDW), .AXI_ID(AXI_ID)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (req_i),
    .we_i     (we_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .be_i     (be_i),
    .gnt_o    (gnt_o),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o),
    .err_o    (err_o),
    .axi      (axi)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reactive AXI slave: records handshakes at posedge, drives at negedge+2.
  initial begin : slave
    bit          txn_aw, txn_w, txn_ar, b_hs, r_hs;
    int          wait_b, wait_r, w_hold;
    bit          pv_aw, pv_w, pv_ar;
    logic [63:0] pa_aw, pa_ar, pd_w;
    logic [7:0]  ps_w;
    txn_aw = 0; txn_w = 0; txn_ar = 0; b_hs = 0; r_hs = 0;
    wait_b = 0; wait_r = 0; w_hold = 0;
    pv_aw = 0; pv_w = 0; pv_ar = 0;
    pa_aw = '0; pa_ar = '0; pd_w = '0; ps_w = '0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
    axi.bvalid = 1'b0; axi.bid = '0; axi.bresp = '0;
    axi.rvalid = 1'b0; axi.rid = '0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 1'b0;
    forever begin
      @(posedge clk_i);
      if (!rst_ni) begin
        txn_aw = 0; txn_w = 0; txn_ar = 0; b_hs = 0; r_hs = 0;
        pv_aw = 0; pv_w = 0; pv_ar = 0;
      end else begin
        // A valid left waiting last cycle must still be up with the same payload.
        if (pv_aw) begin
          check("aw_hold_valid", 64'(axi.awvalid), 64'd1);
          check("aw_hold_addr", axi.awaddr, pa_aw);
        end
        if (pv_w) begin
          check("w_hold_valid", 64'(axi.wvalid), 64'd1);
          check("w_hold_data", axi.wdata, pd_w);
          check("w_hold_strb", 64'(axi.wstrb), 64'(ps_w));
        end
        if (pv_ar) begin
          check("ar_hold_valid", 64'(axi.arvalid), 64'd1);
          check("ar_hold_addr", axi.araddr, pa_ar);
        end
        pv_aw = axi.awvalid && !axi.awready; pa_aw = axi.awaddr;
        pv_w  = axi.wvalid  && !axi.wready;  pd_w  = axi.wdata; ps_w = axi.wstrb;
        pv_ar = axi.arvalid && !axi.arready; pa_ar = axi.araddr;
        if (axi.awvalid && axi.awready) begin
          aw_cnt++; txn_aw = 1; obs_awaddr = axi.awaddr;
          obs_aw_fixed = (axi.awid == ID) && (axi.awlen == 8'd0) &&
                         (axi.awsize == 3'd3) && (axi.awburst == 2'b01);
        end
        if (axi.wvalid && axi.wready) begin
          w_cnt++; txn_w = 1;
          obs_wdata = axi.wdata; obs_wstrb = axi.wstrb; obs_wlast = axi.wlast;
        end
        if (axi.arvalid && axi.arready) begin
          ar_cnt++; txn_ar = 1; obs_araddr = axi.araddr;
          obs_ar_fixed = (axi.arid == ID) && (axi.arlen == 8'd0) &&
                         (axi.arsize == 3'd3) && (axi.arburst == 2'b01);
        end
        if (axi.bvalid && axi.bready) begin txn_aw = 0; txn_w = 0; b_hs = 1; end
        if (axi.rvalid && axi.rready) begin txn_ar = 0; r_hs = 1; end
      end
      @(negedge clk_i);
      #2;
      if (!rst_ni) begin
        axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
        axi.bvalid = 1'b0; axi.rvalid = 1'b0;
        b_hs = 0; r_hs = 0; w_hold = 0;
      end else begin
        if (!txn_aw && !txn_w && !txn_ar && !axi.awvalid && !axi.wvalid && !axi.arvalid) begin
          w_hold = k_w_hold; wait_b = k_b_delay; wait_r = k_r_delay;
        end
        axi.awready = (k_rand_ready != 0) ? 1'($urandom_range(1)) : 1'b1;
        axi.arready = (k_rand_ready != 0) ? 1'($urandom_range(1)) : 1'b1;
        if (w_hold > 0) begin
          axi.wready = 1'b0;
          if (txn_aw) w_hold--;
        end else begin
          axi.wready = (k_rand_ready != 0) ? 1'($urandom_range(1)) : 1'b1;
        end
        if (b_hs) begin
          axi.bvalid = 1'b0; b_hs = 0;
        end else if (txn_aw && txn_w && !axi.bvalid) begin
          if (wait_b > 0) wait_b--;
          else begin
            axi.bvalid = 1'b1; axi.bresp = k_bresp; axi.bid = k_bid;
          end
        end
        if (r_hs) begin
          axi.rvalid = 1'b0; r_hs = 0;
        end else if (txn_ar && !axi.rvalid) begin
          if (wait_r > 0) wait_r--;
          else begin
            axi.rvalid = 1'b1; axi.rdata = k_rdata; axi.rresp = k_rresp;
            axi.rlast = k_rlast; axi.rid = k_rid;
          end
        end
      end
    end
  end

  // One complete access. Entered and left at negedge+1; reports grant wait and
  // completion latency (cycles from grant to rvalid_o).
  task automatic access(input logic a_we, input logic [63:0] a_addr,
                        input logic [63:0] a_wdata, input logic [7:0] a_be,
                        output int lat, output int gwait);
    int   aw0, w0, ar0, t0, n;
    logic aligned, exp_err;
    aw0 = aw_cnt; w0 = w_cnt; ar0 = ar_cnt;
    lat = 0; gwait = 0;
    we_i = a_we; addr_i = a_addr; wdata_i = a_wdata; be_i = a_be; req_i = 1'b1;
    #1;
    while (!gnt_o && gwait < 50) begin
      @(negedge clk_i); #1; gwait++;
    end
    if (!gnt_o) begin
      check("gnt_timeout", 64'd0, 64'd1);
      req_i = 1'b0;
      return;
    end
    t0 = cyc;
    @(negedge clk_i); #1;
    req_i = 1'b0;
    n = 0;
    while (!rvalid_o && n < 200) begin
      @(negedge clk_i); #1; n++;
    end
    check("rvalid_seen", 64'(rvalid_o), 64'd1);
    lat = cyc - t0;
    aligned = (a_addr[2:0] == 3'b000);
    if (!aligned)  exp_err = 1'b1;
    else if (a_we) exp_err = k_bresp[1] | (k_bid != ID);
    else begin
      exp_err    = k_rresp[1] | ~k_rlast | (k_rid != ID);
      last_rdata = k_rdata;
    end
    check("err", 64'(err_o), 64'(exp_err));
    check("rdata", rdata_o, last_rdata);
    check("aw_count", 64'(aw_cnt - aw0), 64'(a_we && aligned));
    check("w_count", 64'(w_cnt - w0), 64'(a_we && aligned));
    check("ar_count", 64'(ar_cnt - ar0), 64'(!a_we && aligned));
    if (a_we && aligned) begin
      check("awaddr", obs_awaddr, a_addr);
      check("aw_fixed", 64'(obs_aw_fixed), 64'd1);
      check("wdata", obs_wdata, a_wdata);
      check("wstrb", 64'(obs_wstrb), 64'(a_be));
      check("wlast", 64'(obs_wlast), 64'd1);
    end
    if (!a_we && aligned) begin
      check("araddr", obs_araddr, a_addr);
      check("ar_fixed", 64'(obs_ar_fixed), 64'd1);
    end
  endtask

  initial begin : main
    int          lat, gw, a0, n, n_rv;
    logic [63:0] a;
    rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0;
    addr_i = '0; wdata_i = '0; be_i = '0;
    repeat (3) @(negedge clk_i);
    #1;
    check("rst_gnt", 64'(gnt_o), 64'd0);
    check("rst_rvalid", 64'(rvalid_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_rdata", rdata_o, 64'd0);
    check("rst_valids", 64'({axi.awvalid, axi.wvalid, axi.arvalid}), 64'd0);
    check("rst_readies", 64'({axi.bready, axi.rready}), 64'd0);
    rst_ni = 1'b1;
    @(negedge clk_i); #1;

    // Basic write, ready-always slave.
    access(1'b1, 64'h0000_0000_0200_4000, 64'h10, 8'hFF, lat, gw);
    check("t1_latency", 64'(lat), 64'd3);
    @(negedge clk_i); #1;
    check("t1_rvalid_pulse", 64'(rvalid_o), 64'd0);

    // Read of mtime.
    k_rdata = 64'h1234;
    access(1'b0, 64'h0000_0000_0200_BFF8, 64'h0, 8'h00, lat, gw);
    check("t2_latency", 64'(lat), 64'd3);

    // W held off for 5 cycles after the AW handshake.
    k_w_hold = 5;
    a0 = aw_cnt;
    fork
      access(1'b1, 64'h0000_0000_0200_4008, 64'hDEAD_BEEF_0000_0001, 8'h0F, lat, gw);
      begin
        n = 0;
        while (aw_cnt == a0 && n < 20) begin
          @(negedge clk_i); #1; n++;
        end
        check("t3_aw_seen", 64'(aw_cnt - a0), 64'd1);
        repeat (3) begin
          check("t3_awvalid_low", 64'(axi.awvalid), 64'd0);
          check("t3_wvalid_high", 64'(axi.wvalid), 64'd1);
          check("t3_wdata", axi.wdata, 64'hDEAD_BEEF_0000_0001);
          @(negedge clk_i); #1;
        end
      end
    join
    check("t3_latency", 64'(lat), 64'd9);
    k_w_hold = 0;

    // Error responses on both channels.
    k_rresp = 2'b10;
    access(1'b0, 64'h0000_0000_0200_BFF8, 64'h0, 8'h00, lat, gw);
    k_rresp = 2'b00;
    k_bresp = 2'b11;
    access(1'b1, 64'h0000_0000_0200_4000, 64'h55, 8'h01, lat, gw);
    k_bresp = 2'b00;

    // Misaligned address completes locally.
    access(1'b1, 64'h0000_0000_0200_4004, 64'h77, 8'hFF, lat, gw);
    check("t5_latency", 64'(lat), 64'd2);

    // Back-to-back: next request granted in the completion cycle.
    k_rdata = 64'hCAFE_F00D_0123_4567;
    access(1'b0, 64'h0000_0000_0200_4000, 64'h0, 8'h00, lat, gw);
    access(1'b1, 64'h0000_0000_0200_0000, 64'h1, 8'h0F, lat, gw);
    check("b2b_gnt_wait", 64'(gw), 64'd0);
    check("b2b_latency", 64'(lat), 64'd3);

    // Reset while waiting for B.
    k_b_delay = 30;
    we_i = 1'b1; addr_i = 64'h0000_0000_0200_4010; wdata_i = 64'h99; be_i = 8'hFF;
    req_i = 1'b1;
    #1;
    check("t6_gnt", 64'(gnt_o), 64'd1);
    @(negedge clk_i); #1;
    req_i = 1'b0;
    n = 0;
    while (!axi.bready && n < 20) begin
      @(negedge clk_i); #1; n++;
    end
    check("t6_in_wait_b", 64'(axi.bready), 64'd1);
    rst_ni = 1'b0;
    #1;
    check("t6_rst_valids", 64'({axi.awvalid, axi.wvalid, axi.arvalid}), 64'd0);
    check("t6_rst_readies", 64'({axi.bready, axi.rready}), 64'd0);
    check("t6_rst_rvalid", 64'(rvalid_o), 64'd0);
    check("t6_rst_rdata", rdata_o, 64'd0);
    last_rdata = '0;
    k_b_delay  = 0;
    repeat (2) @(negedge clk_i);
    #1;
    rst_ni = 1'b1;
    n_rv = 0;
    repeat (4) begin
      @(negedge clk_i); #1;
      if (rvalid_o) n_rv++;
    end
    check("t6_no_rvalid", 64'(n_rv), 64'd0);
    access(1'b1, 64'h0000_0000_0200_4010, 64'hABCD, 8'h3C, lat, gw);
    check("t6_after_latency", 64'(lat), 64'd3);

    // Randomized accesses with random readiness, delays and responses.
    k_rand_ready = 1;
    for (int i = 0; i < 60; i++) begin
      k_bresp   = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b00;
      k_rresp   = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b00;
      k_bid     = ($urandom_range(5) == 0) ? 5'($urandom) : ID;
      k_rid     = ($urandom_range(5) == 0) ? 5'($urandom) : ID;
      k_rlast   = ($urandom_range(7) != 0);
      k_rdata   = {$urandom, $urandom};
      k_b_delay = $urandom_range(3);
      k_r_delay = $urandom_range(3);
      a = {32'h0, 16'h0200, 13'($urandom), 3'b000};
      if ($urandom_range(7) == 0) a[2:0] = 3'($urandom_range(7, 1));
      access(1'($urandom_range(1)), a, {$urandom, $urandom}, 8'($urandom), lat, gw);
      if ($urandom_range(1) == 1) begin
        repeat ($urandom_range(2, 1)) @(negedge clk_i);
        #1;
      end
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
